// File: rtl/contador_display_2b.sv
// Digit-index source for the 7-segment decoder: synchronizes and debounces the
// pushbutton, and steps a 2-bit counter per press (manual) or per prescaler tick
// (automatic). Build option CONT_SATURA_EN: the counter saturates at 0/3 instead
// of wrapping.
module contador_display_2b #(
  parameter int DEB_CICLOS = 4,
  parameter int PRESC      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       botao,
  input  logic       sentido,
  input  logic       modo_auto,
  output logic [1:0] contador,
  output logic       passo,
  output logic       botao_deb
);

  localparam int CW = $clog2(DEB_CICLOS + 1);
  localparam int PW = $clog2(PRESC);
  localparam logic [CW-1:0] DEB_MAX   = CW'(DEB_CICLOS);
  localparam logic [PW-1:0] PRESC_FIM = PW'(PRESC - 1);
  localparam bit            DEB_UM    = (DEB_CICLOS == 1);

  // Debounce states; 'estado' is the observable state for checkers.
  typedef enum logic [1:0] {
    EST0  = 2'd0,
    SOBE  = 2'd1,
    EST1  = 2'd2,
    DESCE = 2'd3
  } estado_t;

  estado_t       estado;
  estado_t       estado_prox;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_prox;
  logic [CW-1:0] cnt_inc;
  logic          s1;
  logic          s2;
  logic          pressao;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_prox;
  logic          tick_auto;
  logic          passo_en;
  logic [1:0]    cont_passo;
  logic          muda;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= botao;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= EST0;
      cnt    <= '0;
    end else begin
      estado <= estado_prox;
      cnt    <= cnt_prox;
    end
  end

  assign cnt_inc = cnt + CW'(1);

  // The first differing sample is counted on the edge that leaves a stable state,
  // so the level changes after exactly DEB_CICLOS consecutive samples.
  always_comb begin
    estado_prox = estado;
    cnt_prox    = cnt;
    case (estado)
      EST0: begin
        if (s2) begin
          if (DEB_UM) begin
            estado_prox = EST1;
            cnt_prox    = '0;
          end else begin
            estado_prox = SOBE;
            cnt_prox    = CW'(1);
          end
        end
      end
      SOBE: begin
        if (!s2) begin
          estado_prox = EST0;
          cnt_prox    = '0;
        end else if (cnt_inc == DEB_MAX) begin
          estado_prox = EST1;
          cnt_prox    = '0;
        end else begin
          cnt_prox = cnt_inc;
        end
      end
      EST1: begin
        if (!s2) begin
          if (DEB_UM) begin
            estado_prox = EST0;
            cnt_prox    = '0;
          end else begin
            estado_prox = DESCE;
            cnt_prox    = CW'(1);
          end
        end
      end
      DESCE: begin
        if (s2) begin
          estado_prox = EST1;
          cnt_prox    = '0;
        end else if (cnt_inc == DEB_MAX) begin
          estado_prox = EST0;
          cnt_prox    = '0;
        end else begin
          cnt_prox = cnt_inc;
        end
      end
      default: begin
        estado_prox = EST0;
        cnt_prox    = '0;
      end
    endcase
  end

  // A press is only the low-to-high transition; a release bounce back into EST1
  // is not a new press.
  always_comb begin
    botao_deb = (estado == EST1) || (estado == DESCE);
    pressao   = ((estado == EST0) || (estado == SOBE)) && (estado_prox == EST1);
  end

  assign tick_auto = modo_auto && (presc == PRESC_FIM);

  always_comb begin
    presc_prox = presc + PW'(1);
    if (!modo_auto || tick_auto) begin
      presc_prox = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else begin
      presc <= presc_prox;
    end
  end

  assign passo_en = modo_auto ? tick_auto : pressao;

  always_comb begin
    cont_passo = contador;
`ifdef CONT_SATURA_EN
    if (sentido) begin
      cont_passo = (contador == 2'd3) ? 2'd3 : contador + 2'd1;
    end else begin
      cont_passo = (contador == 2'd0) ? 2'd0 : contador - 2'd1;
    end
`else
    if (sentido) begin
      cont_passo = contador + 2'd1;
    end else begin
      cont_passo = contador - 2'd1;
    end
`endif
  end

  // passo marks real changes only, so a saturated step stays silent.
  assign muda = passo_en && (cont_passo != contador);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contador <= 2'd0;
      passo    <= 1'b0;
    end else begin
      passo <= muda;
      if (muda) begin
        contador <= cont_passo;
      end
    end
  end

endmodule

// File: tb/tb_contador_display_2b.sv
// Directed bench for contador_display_2b: reset, debounce latency, bounce
// rejection, wrap/saturation, automatic mode and mode exit.
module tb_contador_display_2b;

  localparam int DEB = 4;

  logic       clk;
  logic       rst_n;
  logic       botao;
  logic       sentido;
  logic       modo_auto;
  logic [1:0] contador;
  logic       passo;
  logic       botao_deb;

  int vetores = 0;
  int erros   = 0;
  int passo_cnt = 0;
  bit deb_visto = 1'b0;
  int p0;

  contador_display_2b #(.DEB_CICLOS(DEB), .PRESC(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .botao     (botao),
    .sentido   (sentido),
    .modo_auto (modo_auto),
    .contador  (contador),
    .passo     (passo),
    .botao_deb (botao_deb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (passo) passo_cnt = passo_cnt + 1;
    if (botao_deb) deb_visto = 1'b1;
  end

  task automatic espera(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checa(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    vetores++;
    if (obs !== esp) begin
      erros++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
    end
  endtask

  task automatic aperta(input int hold);
    botao = 1'b1;
    espera(hold);
    botao = 1'b0;
    espera(12);
  endtask

  initial begin
    botao = 1'b0; sentido = 1'b1; modo_auto = 1'b0; rst_n = 1'b0;
    espera(2);
    checa("rst_contador", contador, 0);
    checa("rst_passo", passo, 0);
    checa("rst_deb", botao_deb, 0);
    rst_n = 1'b1;
    espera(2);

    // Clean press: change at the fifth edge after the first high sample.
    p0 = passo_cnt;
    botao = 1'b1;
    espera(5);
    checa("press_cont_antes", contador, 0);
    checa("press_deb_antes", botao_deb, 0);
    espera(1);
    checa("press_cont", contador, 1);
    checa("press_passo", passo, 1);
    checa("press_deb", botao_deb, 1);
    espera(1);
    checa("press_passo_fim", passo, 0);
    espera(13);
    botao = 1'b0;
    espera(12);
    checa("release_cont", contador, 1);
    checa("release_deb", botao_deb, 0);
    checa("press_passo_total", passo_cnt - p0, 1);

    // Reset mid-cycle with a press held.
    botao = 1'b1;
    espera(8);
    checa("pre_rst_cont", contador, 2);
    checa("pre_rst_deb", botao_deb, 1);
    #2 rst_n = 1'b0;
    #1;
    checa("async_rst_cont", contador, 0);
    checa("async_rst_passo", passo, 0);
    checa("async_rst_deb", botao_deb, 0);
    botao = 1'b0;
    espera(2);
    rst_n = 1'b1;
    espera(3);
    checa("post_rst_cont", contador, 0);

    // Bounce shorter than the debounce window.
    p0 = passo_cnt;
    deb_visto = 1'b0;
    for (int i = 0; i < 4; i++) begin
      botao = (i % 2 == 0);
      espera(2);
    end
    botao = 1'b0;
    espera(12);
    checa("bounce_cont", contador, 0);
    checa("bounce_deb", deb_visto, 0);
    checa("bounce_passo", passo_cnt - p0, 0);

    // Down step at 0.
    sentido = 1'b0;
    p0 = passo_cnt;
    aperta(10);
`ifdef CONT_SATURA_EN
    checa("down_wrap_cont", contador, 0);
    checa("down_wrap_passo", passo_cnt - p0, 0);
`else
    checa("down_wrap_cont", contador, 3);
    checa("down_wrap_passo", passo_cnt - p0, 1);
`endif

    rst_n = 1'b0;
    espera(1);
    rst_n = 1'b1;
    espera(2);
    sentido = 1'b1;
    aperta(10);
    checa("setup_auto_cont", contador, 1);

    // Automatic mode with a press inside the window.
    p0 = passo_cnt;
    modo_auto = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      espera(1);
      if (i == 7)  checa("auto_cont_7", contador, 1);
      if (i == 8)  checa("auto_cont_8", contador, 2);
      if (i == 8)  checa("auto_passo_8", passo, 1);
      if (i == 10) checa("auto_deb", botao_deb, 1);
      if (i == 15) checa("auto_cont_15", contador, 2);
      if (i == 16) checa("auto_cont_16", contador, 3);
`ifdef CONT_SATURA_EN
      if (i == 24) checa("auto_cont_24", contador, 3);
`else
      if (i == 24) checa("auto_cont_24", contador, 0);
`endif
      if (i == 3)  botao = 1'b1;
      if (i == 12) botao = 1'b0;
      if (i == 17) sentido = 1'b0;
      if (i == 20) sentido = 1'b1;
    end
    modo_auto = 1'b0;
    espera(1);
`ifdef CONT_SATURA_EN
    checa("auto_passo_total", passo_cnt - p0, 2);
`else
    checa("auto_passo_total", passo_cnt - p0, 3);
`endif

    // Mode exit mid-period, then re-raise.
    sentido = 1'b0;
    espera(12);
    p0 = passo_cnt;
    modo_auto = 1'b1;
    espera(5);
    modo_auto = 1'b0;
    espera(5);
`ifdef CONT_SATURA_EN
    checa("exit_cont", contador, 3);
`else
    checa("exit_cont", contador, 0);
`endif
    checa("exit_passo", passo_cnt - p0, 0);
    modo_auto = 1'b1;
    espera(7);
`ifdef CONT_SATURA_EN
    checa("reraise_cont_7", contador, 3);
    espera(1);
    checa("reraise_cont_8", contador, 2);
`else
    checa("reraise_cont_7", contador, 0);
    espera(1);
    checa("reraise_cont_8", contador, 3);
`endif
    checa("reraise_passo", passo, 1);
    modo_auto = 1'b0;
    espera(2);

    // Manual up steps through the top boundary.
    sentido = 1'b1;
    p0 = passo_cnt;
    aperta(10);
`ifdef CONT_SATURA_EN
    checa("up_top_cont", contador, 3);
    aperta(10);
    checa("up_sat_cont", contador, 3);
    checa("up_passo_total", passo_cnt - p0, 1);
`else
    checa("up_top_cont", contador, 0);
    aperta(10);
    checa("up_sat_cont", contador, 1);
    checa("up_passo_total", passo_cnt - p0, 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
    $finish;
  end

endmodule

// File: doc/contador_display_2b.md
Name: contador_display_2b

Overview:
- Sequential source stage directly upstream of the 7-segment decoder.
- Produces the 2-bit `contador` value that selects one of the four displayed digits (0..3).
- Advances one step per debounced pushbutton press (manual mode) or on a prescaled periodic tick (automatic mode), in the direction set by `sentido`.
- Raw board inputs enter here; the `contador[1:0]` output connects straight to the decoder's `contador` input.

Parameters:
- DEB_CICLOS, 4: consecutive stable synchronized cycles required before the debounced button level changes; legal range >= 1.
- PRESC, 8: clock cycles per automatic step; legal range >= 2.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous reset, active-low.
- botao  input  1  raw pushbutton, active-high, asynchronous to clk, may bounce.
- sentido  input  1  direction: 1 = up (+1 mod 4), 0 = down (-1 mod 4).
- modo_auto  input  1  1 = step on prescaler tick; 0 = step on button press.
- contador  output  2  current digit index, drives the decoder.
- passo  output  1  one-cycle pulse, high in the cycle immediately after each contador update.
- botao_deb  output  1  debounced button level (observability).

Behaviour:
- Reset: asynchronous on rst_n=0. Clears contador, passo, botao_deb, both synchronizer flops, the debounce count and the prescaler to 0. Release is synchronous in effect: the first active edge is the first rising clk with rst_n=1.
- Synchronizer: two-flop chain on botao (s1 then s2). Only s2 is used internally.
- Debounce FSM, 4 states:
  - EST0: stable low, botao_deb=0. Moves to SOBE when s2=1.
  - SOBE: counting high samples. Moves to EST1 when the count reaches DEB_CICLOS. Returns to EST0 with the count cleared if s2=0 in any cycle.
  - EST1: stable high, botao_deb=1. Moves to DESCE when s2=0.
  - DESCE: counting low samples. Moves to EST0 when the count reaches DEB_CICLOS. Returns to EST1 with the count cleared if s2=1 in any cycle.
  - Debounce counter width: $clog2(DEB_CICLOS+1).
- Press event: the edge where the FSM enters EST1.
- Latency: botao first sampled high at edge t and held steady → botao_deb rises and contador changes at edge t+DEB_CICLOS+1. Any bounce shorter than DEB_CICLOS synchronized cycles produces no change.
- Release is debounced the same way and never steps contador.
- Manual step (modo_auto=0): on the press-event edge, contador <= contador+1 mod 4 if sentido=1, else contador-1 mod 4. Exactly one step per press, regardless of hold time.
- Prescaler:
  - Width $clog2(PRESC).
  - Held at 0 while modo_auto=0.
  - While modo_auto=1, increments every cycle. When it equals PRESC-1, it wraps to 0 on the next edge, and contador steps on that same edge.
  - First automatic step occurs on the PRESC-th consecutive edge with modo_auto=1.
- Automatic mode: press events are ignored for stepping. The debouncer keeps running, so botao_deb remains valid.
- sentido is sampled on the stepping edge only. Changing it between steps has no effect until the next step.
- Wrap-around: 3 → 0 going up and 0 → 3 going down (default build).
- modo_auto deasserted mid-period: the prescaler clears to 0 on the next edge and no step occurs. A press event on that same edge is honoured, since manual mode now applies.
- passo: registered. High for exactly one cycle following any edge that changed contador, including a wrap.
- Reset mid-operation: everything returns to reset values immediately. A press in progress is discarded.

Optional Feature:
- Macro: CONT_SATURA_EN.
- Defined: contador saturates. An up-step at 3 keeps 3 and a down-step at 0 keeps 0. passo is NOT pulsed for a saturated step (no change).
- Undefined: modulo-4 wrap as above, and every step pulses passo.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle with contador=2 → contador=0, passo=0, botao_deb=0 immediately, before the next clk edge.
- Clean press, defaults, sentido=1, contador=0: botao rises sampled at edge t and is held 20 cycles → contador=1 at edge t+5; passo high for exactly one cycle; contador stays 1 on release.
- Bounce: botao toggles 1,0,1,0 every 2 cycles, then stays 0 → contador unchanged, botao_deb stays 0, passo never asserts.
- Down wrap: sentido=0, contador=0, one clean press → contador=3, passo pulses once. With CONT_SATURA_EN defined → contador stays 0, no passo.
- Auto mode: modo_auto=1 for 24 cycles, sentido=1, contador=1, botao pressed during the window → contador steps to 2, 3, 0 on the 8th, 16th and 24th edges; the press causes no extra step.
- Mode exit: modo_auto dropped after 5 cycles, then re-raised → no step at the 8-cycle mark; the next step comes 8 edges after re-raise.
